// File: rtl/gb_pkg.sv
// Shared constants and types for the Game Boy style memory subsystem.
//
// Contents:
//   DMA_REG_ADDR  - CPU address of the OAM DMA trigger register (FF46)
//   OAM_BASE      - first byte of object attribute memory (FE00)
//   OAM_LEN       - number of bytes copied by one OAM DMA (160)
//   ECHO_PAGE_MIN - first source page that lies in echo RAM (E0)
//   ECHO_OFFSET   - distance from an echo page down to its work-RAM page
//   dma_state_t   - OAM DMA engine states
//   dma_eff_page  - maps a requested source page onto the page actually read
package gb_pkg;

   localparam logic [15:0] DMA_REG_ADDR  = 16'hFF46;
   localparam logic [15:0] OAM_BASE      = 16'hFE00;
   localparam int          OAM_LEN       = 160;
   localparam logic [7:0]  ECHO_PAGE_MIN = 8'hE0;
   localparam logic [7:0]  ECHO_OFFSET   = 8'h20;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      XFER  = 2'd2
   } dma_state_t;

   // Echo RAM (E000-FDFF) mirrors work RAM at C000-DDFF, so a source page in
   // that range is redirected to the real RAM underneath it.
   function automatic logic [7:0] dma_eff_page(input logic [7:0] page);
      return (page >= ECHO_PAGE_MIN) ? (page - ECHO_OFFSET) : page;
   endfunction

endpackage

// File: rtl/oam_dma.sv
// OAM DMA engine sitting on the CPU memory bus between the CPU and memory.
//
// When idle the CPU bus is passed straight through to memory. A CPU write to
// FF46 latches a source page and starts a copy of 160 bytes from
// {page,00}..{page,9F} into OAM at FE00..FE9F. While the copy runs the engine
// owns the memory bus: CPU reads return FF and CPU writes are dropped, except
// writes to FF46, which are forwarded and restart the copy.
//
// Parameters:
//   CYCLES_PER_BYTE - clocks spent on each byte (>= 2, read latency is 1)
//   START_DELAY     - clocks between the trigger and the first byte (>= 1)
//
// Ports:
//   i_clk, i_rst    - clock and synchronous active-high reset
//   i_cpu_*         - CPU read address and write strobe/address/data
//   o_cpu_rd_data   - read data returned to the CPU
//   o_mem_*         - memory read address and write strobe/address/data
//   i_mem_rd_data   - memory read data, valid one clock after o_mem_rd_addr
//   o_dma_active    - high while the engine owns the bus
module oam_dma
   import gb_pkg::*;
#(
   parameter int CYCLES_PER_BYTE = 4,
   parameter int START_DELAY     = 4
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [15:0] i_cpu_rd_addr,
   input  logic        i_cpu_wr_en,
   input  logic [15:0] i_cpu_wr_addr,
   input  logic [7:0]  i_cpu_wr_data,
   output logic [7:0]  o_cpu_rd_data,
   output logic [15:0] o_mem_rd_addr,
   output logic        o_mem_wr_en,
   output logic [15:0] o_mem_wr_addr,
   output logic [7:0]  o_mem_wr_data,
   input  logic [7:0]  i_mem_rd_data,
   output logic        o_dma_active
);

   // One sub-counter serves both the start delay and the per-byte period.
   localparam int SUB_MAX = (CYCLES_PER_BYTE > START_DELAY) ? CYCLES_PER_BYTE : START_DELAY;
   localparam int SUB_W   = (SUB_MAX < 2) ? 1 : $clog2(SUB_MAX);

   localparam logic [SUB_W-1:0] START_LAST = SUB_W'(START_DELAY - 1);
   localparam logic [SUB_W-1:0] BYTE_LAST  = SUB_W'(CYCLES_PER_BYTE - 1);
   localparam logic [7:0]       LAST_INDEX = 8'(OAM_LEN - 1);

   dma_state_t       state_reg, state_next;
   logic [7:0]       index_reg, index_next;
   logic [SUB_W-1:0] sub_reg,   sub_next;
   logic [7:0]       page_reg,  page_next;

   logic       trigger;
   logic       active;
   logic       byte_done;
   logic       dma_wr;
   logic [7:0] eff_page;

   assign trigger   = i_cpu_wr_en && (i_cpu_wr_addr == DMA_REG_ADDR);
   assign active    = (state_reg != IDLE);
   assign byte_done = (state_reg == XFER) && (sub_reg == BYTE_LAST);
   // No OAM write is issued in the clock where reset is being applied, so a
   // reset during a byte leaves that byte untouched.
   assign dma_wr    = byte_done && !i_rst;
   assign eff_page  = dma_eff_page(page_reg);

   // ------------------------------------------------------------------
   // State and counter registers
   // ------------------------------------------------------------------
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_reg <= IDLE;
         index_reg <= '0;
         sub_reg   <= '0;
         page_reg  <= '0;
      end else begin
         state_reg <= state_next;
         index_reg <= index_next;
         sub_reg   <= sub_next;
         page_reg  <= page_next;
      end
   end

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_next = state_reg;
      index_next = index_reg;
      sub_next   = sub_reg;
      page_next  = page_reg;

      case (state_reg)
         IDLE: begin
         end
         START: begin
            if (sub_reg == START_LAST) begin
               state_next = XFER;
               sub_next   = '0;
               index_next = '0;
            end else begin
               sub_next = sub_reg + 1'b1;
            end
         end
         XFER: begin
            if (byte_done) begin
               sub_next = '0;
               if (index_reg == LAST_INDEX) begin
                  state_next = IDLE;
                  index_next = '0;
               end else begin
                  index_next = index_reg + 1'b1;
               end
            end else begin
               sub_next = sub_reg + 1'b1;
            end
         end
         default: begin
            state_next = IDLE;
            sub_next   = '0;
            index_next = '0;
         end
      endcase

      // A write to FF46 in any state (re)starts the copy. Any DMA write in
      // this same clock is still driven below from the current registers.
      if (trigger) begin
         state_next = START;
         sub_next   = '0;
         index_next = '0;
         page_next  = i_cpu_wr_data;
      end
   end

   // ------------------------------------------------------------------
   // Bus multiplexer
   // ------------------------------------------------------------------
   always_comb begin
      o_cpu_rd_data = i_mem_rd_data;
      o_mem_rd_addr = i_cpu_rd_addr;
      o_mem_wr_en   = i_cpu_wr_en;
      o_mem_wr_addr = i_cpu_wr_addr;
      o_mem_wr_data = i_cpu_wr_data;

      if (active) begin
         o_cpu_rd_data = 8'hFF;
         o_mem_rd_addr = {eff_page, index_reg};
         // Only the trigger register stays writable by the CPU.
         o_mem_wr_en   = trigger;
         if (dma_wr) begin
            // The DMA write wins over a coincident CPU write. Index never
            // exceeds 9F so the address stays inside FE00..FE9F.
            o_mem_wr_en   = 1'b1;
            o_mem_wr_addr = {OAM_BASE[15:8], index_reg};
            o_mem_wr_data = i_mem_rd_data;
         end
      end
   end

   assign o_dma_active = active;

endmodule

// File: tb/tb_oam_dma.sv
// Self-checking bench for oam_dma. A behavioural 64 KiB synchronous-read
// memory sits behind the DMA; a golden copy of everything the bench loads is
// used to predict OAM contents, active duration and write counts.
module tb_oam_dma;

   localparam int CPB = 4;
   localparam int SD  = 4;
   localparam int LEN = 160;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] cpu_rd_addr;
   logic        cpu_wr_en;
   logic [15:0] cpu_wr_addr;
   logic [7:0]  cpu_wr_data;
   logic [7:0]  cpu_rd_data;
   logic [15:0] mem_rd_addr;
   logic        mem_wr_en;
   logic [15:0] mem_wr_addr;
   logic [7:0]  mem_wr_data;
   logic [7:0]  mem_rd_data;
   logic        dma_active;

   // backdoor load port into the bench memory
   logic        bd_we;
   logic [15:0] bd_addr;
   logic [7:0]  bd_data;

   logic [7:0] mem  [0:65535];
   logic [7:0] gold [0:65535];

   int checks = 0;
   int errors = 0;
   int act_cnt = 0;
   int wr_cnt = 0;
   int bad_cnt = 0;

   always #5 clk = ~clk;

   oam_dma #(.CYCLES_PER_BYTE(CPB), .START_DELAY(SD)) dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_cpu_rd_addr (cpu_rd_addr),
      .i_cpu_wr_en   (cpu_wr_en),
      .i_cpu_wr_addr (cpu_wr_addr),
      .i_cpu_wr_data (cpu_wr_data),
      .o_cpu_rd_data (cpu_rd_data),
      .o_mem_rd_addr (mem_rd_addr),
      .o_mem_wr_en   (mem_wr_en),
      .o_mem_wr_addr (mem_wr_addr),
      .o_mem_wr_data (mem_wr_data),
      .i_mem_rd_data (mem_rd_data),
      .o_dma_active  (dma_active)
   );

   always @(posedge clk) begin
      if (mem_wr_en)
         mem[mem_wr_addr] <= mem_wr_data;
      else if (bd_we)
         mem[bd_addr] <= bd_data;
      mem_rd_data <= mem[mem_rd_addr];
   end

   // Sample bus activity for the coming edge, then advance to the next negedge.
   task automatic tick();
      #1;
      if (dma_active === 1'b1) act_cnt++;
      if (mem_wr_en === 1'b1 && mem_wr_addr[15:8] == 8'hFE) begin
         if (mem_wr_addr[7:0] < 8'hA0) wr_cnt++;
         else bad_cnt++;
      end
      @(negedge clk);
   endtask

   task automatic bd_write(input logic [15:0] a, input logic [7:0] d);
      bd_we = 1'b1; bd_addr = a; bd_data = d;
      gold[a] = d;
      tick();
      bd_we = 1'b0;
   endtask

   task automatic preload_random(input logic [7:0] page);
      for (int i = 0; i < LEN; i++) bd_write({page, 8'(i)}, 8'($urandom));
   endtask

   task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
      cpu_wr_en = 1'b1; cpu_wr_addr = a; cpu_wr_data = d;
      tick();
      cpu_wr_en = 1'b0;
   endtask

   function automatic logic [7:0] model_page(input logic [7:0] p);
      return (p >= 8'hE0) ? p - 8'h20 : p;
   endfunction

   task automatic wait_done(input string name);
      int n = 0;
      while (dma_active === 1'b1 && n < 3000) begin
         tick();
         n++;
      end
      checks++;
      if (dma_active !== 1'b0) begin
         errors++;
         $display("FAIL %s timeout: dma_active=%b after %0d clocks, required 0", name, dma_active, n);
      end
   endtask

   // Expected OAM byte i = golden source byte at the effective page.
   task automatic check_oam(input logic [7:0] page, input int lo, input int hi, input string name);
      logic [7:0] ep;
      logic [7:0] exp;
      ep = model_page(page);
      for (int i = lo; i < hi; i++) begin
         exp = gold[{ep, 8'(i)}];
         checks++;
         if (mem[16'hFE00 + 16'(i)] !== exp) begin
            errors++;
            $display("FAIL %s oam[%0d]: got %h required %h", name, i, mem[16'hFE00 + 16'(i)], exp);
         end
         gold[16'hFE00 + 16'(i)] = exp;
      end
   endtask

   task automatic check_untouched(input int lo, input int hi, input string name);
      for (int i = lo; i < hi; i++) begin
         checks++;
         if (mem[16'hFE00 + 16'(i)] !== gold[16'hFE00 + 16'(i)]) begin
            errors++;
            $display("FAIL %s oam[%0d]: got %h required %h", name, i,
                     mem[16'hFE00 + 16'(i)], gold[16'hFE00 + 16'(i)]);
         end
      end
   endtask

   task automatic check_int(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d required %0d", name, got, exp);
      end
   endtask

   task automatic check_readback(input logic [15:0] a, input logic [7:0] exp, input string name);
      cpu_rd_addr = a;
      tick();
      #1;
      checks++;
      if (cpu_rd_data !== exp) begin
         errors++;
         $display("FAIL %s: read %h got %h required %h", name, a, cpu_rd_data, exp);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      #1;
      checks++;
      if (dma_active !== 1'b0) begin
         errors++;
         $display("FAIL reset_active: got %b required 0", dma_active);
      end
      rst = 1'b0;
      cpu_wr_addr = 16'hC055; cpu_wr_data = 8'h3C; cpu_rd_addr = 16'hC077;
      #1;
      checks++;
      if (mem_wr_addr !== 16'hC055 || mem_wr_data !== 8'h3C || mem_rd_addr !== 16'hC077 || mem_wr_en !== 1'b0) begin
         errors++;
         $display("FAIL reset_passthru: wr_addr %h data %h rd_addr %h en %b required C055 3C C077 0",
                  mem_wr_addr, mem_wr_data, mem_rd_addr, mem_wr_en);
      end
      tick();
      $display("test_reset done");
   endtask

   task automatic test_idle_passthrough();
      logic [7:0] d;
      d = 8'h42;
      cpu_wr_en = 1'b1; cpu_wr_addr = 16'hC123; cpu_wr_data = d;
      #1;
      checks++;
      if (mem_wr_en !== 1'b1 || mem_wr_addr !== 16'hC123 || mem_wr_data !== d) begin
         errors++;
         $display("FAIL idle_write: en %b addr %h data %h required 1 C123 %h", mem_wr_en, mem_wr_addr, mem_wr_data, d);
      end
      tick();
      cpu_wr_en = 1'b0;
      gold[16'hC123] = d;
      check_readback(16'hC123, d, "idle_read");
      $display("test_idle_passthrough wrote C123=%h", d);
   endtask

   task automatic test_basic();
      int a0, w0, b0;
      for (int i = 0; i < LEN; i++) bd_write({8'hC0, 8'(i)}, 8'(i) ^ 8'h5A);
      for (int i = 0; i < LEN; i++) bd_write(16'hFE00 + 16'(i), 8'($urandom));
      bd_write(16'hFEA0, 8'h77);
      a0 = act_cnt; w0 = wr_cnt; b0 = bad_cnt;
      cpu_wr_en = 1'b1; cpu_wr_addr = 16'hFF46; cpu_wr_data = 8'hC0;
      #1;
      checks++;
      if (mem_wr_en !== 1'b1 || mem_wr_addr !== 16'hFF46 || dma_active !== 1'b0) begin
         errors++;
         $display("FAIL trigger_forward: en %b addr %h active %b required 1 FF46 0", mem_wr_en, mem_wr_addr, dma_active);
      end
      tick();
      cpu_wr_en = 1'b0;
      gold[16'hFF46] = 8'hC0;
      #1;
      checks++;
      if (dma_active !== 1'b1) begin
         errors++;
         $display("FAIL active_start: got %b required 1", dma_active);
      end
      for (int i = 0; i < 20; i++) tick();
      cpu_rd_addr = 16'hC000;
      tick();
      tick();
      #1;
      checks++;
      if (cpu_rd_data !== 8'hFF) begin
         errors++;
         $display("FAIL isolate_read: got %h required FF", cpu_rd_data);
      end
      cpu_wr_en = 1'b1; cpu_wr_addr = 16'hC010; cpu_wr_data = 8'h11;
      #1;
      checks++;
      if (mem_wr_en === 1'b1 && mem_wr_addr === 16'hC010) begin
         errors++;
         $display("FAIL isolate_write: CPU write to C010 forwarded, required blocked");
      end
      tick();
      cpu_wr_en = 1'b0;
      wait_done("basic");
      check_int("basic_active_clocks", act_cnt - a0, SD + LEN * CPB);
      check_int("basic_oam_writes", wr_cnt - w0, LEN);
      check_int("basic_beyond_oam", bad_cnt - b0, 0);
      check_oam(8'hC0, 0, LEN, "basic");
      checks++;
      if (mem[16'hFEA0] !== 8'h77) begin
         errors++;
         $display("FAIL fea0_kept: got %h required 77", mem[16'hFEA0]);
      end
      checks++;
      if (mem[16'hC010] !== gold[16'hC010]) begin
         errors++;
         $display("FAIL c010_kept: got %h required %h", mem[16'hC010], gold[16'hC010]);
      end
      check_readback(16'hFF46, 8'hC0, "ff46_read");
      $display("test_basic page C0 active=%0d writes=%0d", act_cnt - a0, wr_cnt - w0);
   endtask

   task automatic test_echo();
      int w0;
      preload_random(8'hC1);
      preload_random(8'hE1);
      w0 = wr_cnt;
      cpu_write(16'hFF46, 8'hE1);
      gold[16'hFF46] = 8'hE1;
      wait_done("echo");
      check_int("echo_oam_writes", wr_cnt - w0, LEN);
      check_oam(8'hE1, 0, LEN, "echo");
      $display("test_echo page E1 -> C1 writes=%0d", wr_cnt - w0);
   endtask

   task automatic test_restart();
      int a0, w0, k;
      int glitch = 0;
      logic dropped;
      preload_random(8'hD0);
      a0 = act_cnt; w0 = wr_cnt;
      cpu_write(16'hFF46, 8'hC0);
      gold[16'hFF46] = 8'hC0;
      for (int j = 1; j <= 300; j++) begin
         if (j == 300) begin
            cpu_wr_en = 1'b1; cpu_wr_addr = 16'hFF46; cpu_wr_data = 8'hD0;
         end
         #1;
         if (dma_active !== 1'b1) glitch++;
         tick();
      end
      cpu_wr_en = 1'b0;
      // The restart lands on active clock k; it collides with a DMA write when
      // k is the last clock of a byte period, and then the CPU write is lost.
      k = 299;
      dropped = (k >= SD) && (((k - SD) % CPB) == CPB - 1) && (((k - SD) / CPB) < LEN);
      if (!dropped) gold[16'hFF46] = 8'hD0;
      for (int j = 0; j < 4; j++) begin
         #1;
         if (dma_active !== 1'b1) glitch++;
         tick();
      end
      check_int("restart_no_glitch", glitch, 0);
      wait_done("restart");
      check_int("restart_active_clocks", act_cnt - a0, 300 + SD + LEN * CPB);
      check_int("restart_oam_writes", wr_cnt - w0, (300 - SD) / CPB + LEN);
      check_oam(8'hD0, 0, LEN, "restart");
      check_readback(16'hFF46, gold[16'hFF46], "restart_ff46");
      $display("test_restart C0->D0 active=%0d writes=%0d dropped=%b", act_cnt - a0, wr_cnt - w0, dropped);
   endtask

   task automatic test_reset_mid();
      int w0, n;
      for (int i = 0; i < LEN; i++) bd_write(16'hFE00 + 16'(i), 8'($urandom));
      preload_random(8'hC2);
      w0 = wr_cnt;
      cpu_write(16'hFF46, 8'hC2);
      n = 0;
      while ((wr_cnt - w0) < 50 && n < 3000) begin
         tick();
         n++;
      end
      check_int("reset_mid_reach50", wr_cnt - w0, 50);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      checks++;
      if (dma_active !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_active: got %b required 0", dma_active);
      end
      for (int i = 0; i < 40; i++) tick();
      check_int("reset_mid_writes", wr_cnt - w0, 50);
      check_oam(8'hC2, 0, 50, "reset_mid_written");
      check_untouched(50, LEN, "reset_mid_kept");
      preload_random(8'hD1);
      w0 = wr_cnt;
      cpu_write(16'hFF46, 8'hD1);
      wait_done("after_reset");
      check_int("after_reset_writes", wr_cnt - w0, LEN);
      check_oam(8'hD1, 0, LEN, "after_reset");
      $display("test_reset_mid stopped at byte 50, rerun writes=%0d", wr_cnt - w0);
   endtask

   initial begin
      rst = 1'b1;
      cpu_rd_addr = 16'h0000;
      cpu_wr_en = 1'b0;
      cpu_wr_addr = 16'h0000;
      cpu_wr_data = 8'h00;
      bd_we = 1'b0;
      bd_addr = 16'h0000;
      bd_data = 8'h00;
      @(negedge clk);
      test_reset();
      test_idle_passthrough();
      test_basic();
      test_echo();
      test_restart();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/oam_dma.md
Name: oam_dma

Overview:
- OAM DMA engine placed between `cpu` and `memory` in `top`, on the CPU memory bus.
- Snoops CPU writes to FF46. On such a write it copies 160 bytes from {page,8'h00}..{page,8'h9F} to FE00..FE9F through the memory's single read port and single write port.
- Owns the memory bus while the copy runs and blocks the CPU from it.
- Passes CPU traffic straight through when idle.

Parameters:
- CYCLES_PER_BYTE, 4, clocks per transferred byte (one M-cycle). Must be >= 2.
- START_DELAY, 4, clocks from the trigger to the first byte period.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  synchronous active-high reset.
- i_cpu_rd_addr  in  16  CPU read address.
- i_cpu_wr_en  in  1  CPU write strobe.
- i_cpu_wr_addr  in  16  CPU write address.
- i_cpu_wr_data  in  8  CPU write data.
- o_cpu_rd_data  out  8  read data returned to the CPU.
- o_mem_rd_addr  out  16  to memory read address.
- o_mem_wr_en  out  1  to memory write strobe.
- o_mem_wr_addr  out  16  to memory write address.
- o_mem_wr_data  out  8  to memory write data.
- i_mem_rd_data  in  8  from memory. Valid one clock after o_mem_rd_addr (synchronous read).
- o_dma_active  out  1  high while the engine owns the bus.

Behaviour:
- Reset:
  - State = IDLE, byte index = 0, sub-counter = 0, page = 8'h00, o_dma_active = 0.
  - Memory outputs go to pass-through.
- IDLE (pass-through, combinational):
  - o_mem_* = i_cpu_*.
  - o_cpu_rd_data = i_mem_rd_data.
- Trigger:
  - Condition: i_cpu_wr_en=1 and i_cpu_wr_addr=16'hFF46, sampled at edge T.
  - The write is also forwarded to memory, so FF46 reads back the written value.
  - The write data is latched as page.
  - If page >= 8'hE0, the effective page is page-8'h20 (echo RAM mirror onto C0-DF).
- States: IDLE -> START -> XFER -> IDLE.
- START:
  - Entered at T+1; o_dma_active=1 from T+1.
  - Lasts START_DELAY clocks, then XFER with index=0, sub=0.
  - No memory writes occur.
- XFER:
  - o_mem_rd_addr = {eff_page, index} for all CYCLES_PER_BYTE clocks of the byte.
  - On sub = CYCLES_PER_BYTE-1: o_mem_wr_en=1, o_mem_wr_addr = 16'hFE00+index, o_mem_wr_data = i_mem_rd_data.
  - Then index increments and sub resets to 0.
  - After the write of index 159 (8'h9F): next state IDLE, o_dma_active=0 on the following clock.
- Timing:
  - Total active clocks = START_DELAY + 160*CYCLES_PER_BYTE (644 with defaults).
  - Exactly 160 memory writes per completed transfer.
- CPU isolation while active (START or XFER):
  - o_cpu_rd_data = 8'hFF.
  - CPU writes are not forwarded, except FF46.
- Restart:
  - A CPU write to FF46 while active is forwarded to memory.
  - It relatches the page, resets index and sub to 0, and re-enters START.
  - o_dma_active stays 1 throughout; no glitch low.
- Simultaneous events:
  - A restart write on the same clock as a DMA write cycle: the DMA write still occurs with the old page/index; the CPU write is dropped in favour of the DMA write.
  - The restart takes effect next clock.
- Reset mid-transfer:
  - Next clock is IDLE, o_dma_active=0, no further OAM writes.
  - Already-written OAM bytes are kept.
- Index is 8-bit and never exceeds 159; no wrap into FEA0+.
- Unused high bits are never asserted on o_mem_wr_addr during DMA.

Decomposition:
- Shared package gb_pkg holds:
  - DMA_REG_ADDR = 16'hFF46
  - OAM_BASE = 16'hFE00
  - OAM_LEN = 160
  - ECHO_PAGE_MIN = 8'hE0, ECHO_OFFSET = 8'h20
  - typedef enum dma_state_t {IDLE, START, XFER}
- No sub-module: a single FSM with counters and an output mux.
- `top` instantiates oam_dma between `cpu` and `memory`.

Test Plan:
- Preload C000..C09F with i^8'h5A. Write 8'hC0 to FF46 -> o_dma_active high for exactly 644 clocks; FE00..FE9F = i^8'h5A; FEA0 unchanged; FF46 reads 8'hC0.
- During the transfer, CPU reads C000 and writes 8'h11 to C010 -> read returns 8'hFF; C010 unchanged after completion.
- Write 8'hE1 to FF46 with E100 region unmapped and C100..C19F preloaded -> OAM receives C100..C19F data.
- Write 8'hC0, then at clock 300 write 8'hD0 -> active stays 1; OAM ends with D000..D09F data; total active = 300 + 644 clocks.
- Assert i_rst for 1 clock at byte 50 -> o_dma_active 0 next clock; OAM 0..49 written, 50..159 unchanged; a subsequent FF46 write runs a full transfer.
- Idle pass-through: CPU writes 8'h42 to C123 and reads it back -> memory gets the write the same clock; read returns 8'h42.
